pdmod_ctrl: RTL and testbench

- Frame-level sequencer placed in front of the payload de-modulation chain (noise-floor unit, descramblers, LLR calculator).
- Per payload frame it:
  - accepts a symbol count;
  - loads the noise variance sigma2 exactly once, before any payload sample;
  - gates equalized samples into the chain, counting subcarriers and symbols;
  - counts returned LLRs and signals frame completion, with a stall timeout.

---
 rtl/pdmod_ctrl.sv | 157 +++++++++++++++
 tb/tb_pdmod_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pdmod_ctrl.sv
// Frame sequencer in front of the payload demod chain: loads sigma2 once per frame,
// gates equalized samples in, counts returned LLRs and flags completion or a drain stall.
module pdmod_ctrl #(
    parameter int unsigned NSC        = 48,
    parameter int unsigned LLR_PER_SC = 2,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cfg_start_i,
    input  logic [7:0]         cfg_nsym_i,
    input  logic signed [11:0] sig_sigma2_i,
    input  logic               sig_sigma2_vld_i,
    input  logic signed [11:0] in_re_i,
    input  logic signed [11:0] in_im_i,
    input  logic               in_vld_i,
    output logic signed [11:0] pd_re_o,
    output logic signed [11:0] pd_im_o,
    output logic               pd_vld_o,
    output logic signed [11:0] pd_sigma2_o,
    output logic               pd_sigma2_vld_o,
    input  logic               llr_vld_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_drop_o,
    output logic               err_timeout_o
);

    localparam int unsigned ScW = (NSC > 1) ? $clog2(NSC) : 1;
    localparam int unsigned ToW = $clog2(TIMEOUT) + 1;
    localparam logic [ScW-1:0] ScLast = ScW'(NSC - 1);
    localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT - 1);
    localparam logic [15:0] LlrPerSym = 16'(NSC * LLR_PER_SC);

    typedef enum logic [2:0] {StIdle, StWaitSig, StRun, StDrain, StDone} state_e;

    state_e             state_q;
    logic [7:0]         nsym_q;
    logic [ScW-1:0]     sc_cnt_q;
    logic [7:0]         sym_cnt_q;
    logic [15:0]        llr_cnt_q;
    logic [15:0]        llr_cnt_d;
    logic [15:0]        llr_tgt_q;
    logic [ToW-1:0]     to_cnt_q;
    logic signed [11:0] pd_re_q, pd_im_q, pd_sigma2_q;
    logic               pd_vld_q, pd_sigma2_vld_q;
    logic               busy_q, done_q, err_drop_q, err_timeout_q;
    logic               last_sample;

    always_comb begin
        llr_cnt_d = llr_cnt_q;
        if (llr_vld_i && (state_q == StRun || state_q == StDrain)) begin
            llr_cnt_d = llr_cnt_q + 16'd1;
        end
        last_sample = in_vld_i && (sc_cnt_q == ScLast) && (sym_cnt_q == nsym_q - 8'd1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= StIdle;
            nsym_q          <= '0;
            sc_cnt_q        <= '0;
            sym_cnt_q       <= '0;
            llr_cnt_q       <= '0;
            llr_tgt_q       <= '0;
            to_cnt_q        <= '0;
            pd_re_q         <= '0;
            pd_im_q         <= '0;
            pd_vld_q        <= 1'b0;
            pd_sigma2_q     <= '0;
            pd_sigma2_vld_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            err_drop_q      <= 1'b0;
            err_timeout_q   <= 1'b0;
        end else begin
            pd_vld_q        <= 1'b0;
            pd_sigma2_vld_q <= 1'b0;
            done_q          <= 1'b0;
            err_timeout_q   <= 1'b0;
            err_drop_q      <= in_vld_i && (state_q != StRun);
            llr_cnt_q       <= llr_cnt_d;
            unique case (state_q)
                StIdle: begin
                    if (cfg_start_i) begin
                        if (cfg_nsym_i == 8'd0) begin
                            done_q <= 1'b1;
                        end else begin
                            nsym_q    <= cfg_nsym_i;
                            llr_tgt_q <= 16'(cfg_nsym_i) * LlrPerSym;
                            sc_cnt_q  <= '0;
                            sym_cnt_q <= '0;
                            llr_cnt_q <= '0;
                            to_cnt_q  <= '0;
                            busy_q    <= 1'b1;
                            state_q   <= StWaitSig;
                        end
                    end
                end
                StWaitSig: begin
                    if (sig_sigma2_vld_i) begin
                        pd_sigma2_q     <= sig_sigma2_i;
                        pd_sigma2_vld_q <= 1'b1;
                        state_q         <= StRun;
                    end
                end
                StRun: begin
                    if (in_vld_i) begin
                        pd_vld_q <= 1'b1;
                        pd_re_q  <= in_re_i;
                        pd_im_q  <= in_im_i;
                        if (sc_cnt_q == ScLast) begin
                            sc_cnt_q  <= '0;
                            sym_cnt_q <= sym_cnt_q + 8'd1;
                        end else begin
                            sc_cnt_q <= sc_cnt_q + 1'b1;
                        end
                        if (last_sample) begin
                            to_cnt_q <= '0;
                            state_q  <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    // Target check uses the count including this cycle's LLR.
                    if (llr_cnt_d >= llr_tgt_q) begin
                        state_q <= StDone;
                    end else if (llr_vld_i) begin
                        to_cnt_q <= '0;
                    end else if (to_cnt_q == ToLast) begin
                        err_timeout_q <= 1'b1;
                        state_q       <= StDone;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign pd_re_o         = pd_re_q;
    assign pd_im_o         = pd_im_q;
    assign pd_vld_o        = pd_vld_q;
    assign pd_sigma2_o     = pd_sigma2_q;
    assign pd_sigma2_vld_o = pd_sigma2_vld_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign err_drop_o      = err_drop_q;
    assign err_timeout_o   = err_timeout_q;

endmodule

// File: tb/tb_pdmod_ctrl.sv
// Directed-plus-random bench for pdmod_ctrl, checked every cycle against a frame-level model.
module tb_pdmod_ctrl;

    localparam int NSC     = 48;
    localparam int LLRPSC  = 2;
    localparam int TIMEOUT = 1024;
    localparam int PhIdle = 0, PhWait = 1, PhAccept = 2, PhDrain = 3, PhFinish = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst = 1'b1, cfg_start = 1'b0, sig_vld = 1'b0, in_vld = 1'b0;
    logic               llr_vld = 1'b0;
    logic [7:0]         cfg_nsym = '0;
    logic signed [11:0] sig = '0, in_re = '0, in_im = '0;
    logic signed [11:0] pd_re, pd_im, pd_s2;
    logic               pd_vld, pd_s2v, busy, done, err_drop, err_to;

    pdmod_ctrl dut (
        .clk_i(clk), .rst_i(rst), .cfg_start_i(cfg_start), .cfg_nsym_i(cfg_nsym),
        .sig_sigma2_i(sig), .sig_sigma2_vld_i(sig_vld),
        .in_re_i(in_re), .in_im_i(in_im), .in_vld_i(in_vld),
        .pd_re_o(pd_re), .pd_im_o(pd_im), .pd_vld_o(pd_vld),
        .pd_sigma2_o(pd_s2), .pd_sigma2_vld_o(pd_s2v), .llr_vld_i(llr_vld),
        .busy_o(busy), .done_o(done), .err_drop_o(err_drop), .err_timeout_o(err_to)
    );

    int n_assert = 0, n_fail = 0, cyc = 0;
    int m_phase = PhIdle, m_nsym = 0, m_fwd = 0, m_llr = 0, m_quiet = 0;
    logic signed [11:0] e_re = '0, e_im = '0, e_s2 = '0;
    logic e_pdv, e_s2v, e_busy, e_done, e_drop, e_to;
    int t_pdv, t_done, t_drop, t_to, t_s2v;
    int to_edge = -1, done_edge = -1, last_llr_edge = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Frame-level reference: tracks samples forwarded and LLRs returned against the frame totals.
    task automatic model_step();
        e_pdv = 0; e_s2v = 0; e_done = 0; e_drop = 0; e_to = 0;
        if (rst) begin
            m_phase = PhIdle; m_nsym = 0; m_fwd = 0; m_llr = 0; m_quiet = 0;
            e_re = '0; e_im = '0; e_s2 = '0; e_busy = 0;
        end else begin
            if (in_vld && m_phase != PhAccept) e_drop = 1;
            case (m_phase)
                PhIdle: if (cfg_start) begin
                    if (cfg_nsym == 0) e_done = 1;
                    else begin
                        m_nsym = int'(cfg_nsym); m_fwd = 0; m_llr = 0; m_phase = PhWait;
                    end
                end
                PhWait: if (sig_vld) begin
                    e_s2 = sig; e_s2v = 1; m_phase = PhAccept;
                end
                PhAccept: begin
                    if (llr_vld) m_llr++;
                    if (in_vld) begin
                        e_pdv = 1; e_re = in_re; e_im = in_im; m_fwd++;
                        if (m_fwd == m_nsym * NSC) begin m_phase = PhDrain; m_quiet = 0; end
                    end
                end
                PhDrain: begin
                    if (llr_vld) m_llr++;
                    if (m_llr >= m_nsym * NSC * LLRPSC) m_phase = PhFinish;
                    else if (llr_vld) m_quiet = 0;
                    else if (m_quiet == TIMEOUT - 1) begin e_to = 1; m_phase = PhFinish; end
                    else m_quiet++;
                end
                PhFinish: begin e_done = 1; m_phase = PhIdle; end
                default: m_phase = PhIdle;
            endcase
            e_busy = (m_phase != PhIdle);
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        chk("pd_vld", 32'(pd_vld), 32'(e_pdv));
        chk("pd_re", 32'(pd_re), 32'(e_re));
        chk("pd_im", 32'(pd_im), 32'(e_im));
        chk("pd_sigma2", 32'(pd_s2), 32'(e_s2));
        chk("pd_sigma2_vld", 32'(pd_s2v), 32'(e_s2v));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("done", 32'(done), 32'(e_done));
        chk("err_drop", 32'(err_drop), 32'(e_drop));
        chk("err_timeout", 32'(err_to), 32'(e_to));
        t_pdv += int'(pd_vld); t_done += int'(done); t_drop += int'(err_drop);
        t_to += int'(err_to); t_s2v += int'(pd_s2v);
        if (err_to) to_edge = cyc;
        if (done) done_edge = cyc;
    endtask

    task automatic clear_tally();
        t_pdv = 0; t_done = 0; t_drop = 0; t_to = 0; t_s2v = 0;
        to_edge = -1; done_edge = -1; last_llr_edge = -1;
    endtask

    task automatic start(input int n);
        cfg_start = 1; cfg_nsym = 8'(n);
        step();
        cfg_start = 0;
    endtask

    task automatic load_sigma(input logic signed [11:0] v);
        sig = v; sig_vld = 1;
        step();
        sig_vld = 0;
        chk("sigma_pulse", 32'(pd_s2v), 32'd1);
        chk("sigma_value", 32'(pd_s2), 32'(v));
    endtask

    // Supplies n_samp samples (gap_max>0 inserts random idle cycles) and n_llr LLR valids,
    // at most llr_run_max of them while samples are still being supplied.
    task automatic feed(input int n_samp, input int gap_max, input int n_llr,
                        input int llr_run_max);
        int given = 0, lgiven = 0, guard = 0;
        while ((given < n_samp || lgiven < n_llr) && guard < 5000) begin
            in_vld = (given < n_samp) && ($urandom_range(0, gap_max) == 0);
            if (in_vld) begin
                in_re = 12'($urandom); in_im = 12'($urandom); given++;
            end
            if (lgiven >= n_llr) llr_vld = 0;
            else if (given >= n_samp) llr_vld = 1;
            else llr_vld = (lgiven < llr_run_max) && ($urandom_range(0, 1) == 1);
            if (llr_vld) begin
                lgiven++;
                if (lgiven == n_llr) last_llr_edge = cyc + 1;
            end
            step();
            guard++;
        end
        in_vld = 0; llr_vld = 0;
    endtask

    task automatic wait_done(input int bound);
        int k = 0;
        while (t_done == 0 && k < bound) begin
            step();
            k++;
        end
        chk("done_within_bound", 32'(t_done), 32'd1);
    endtask

    initial begin
        clear_tally();
        // Reset state
        repeat (3) step();
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_pd_vld", 32'(pd_vld), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        rst = 0;
        step();

        // Nominal frame
        clear_tally();
        start(2);
        step();
        load_sigma(12'sh0A0);
        feed(96, 0, 192, 100);
        wait_done(50);
        chk("nom_pd_count", 32'(t_pdv), 32'd96);
        chk("nom_drop_count", 32'(t_drop), 32'd0);
        chk("nom_sigma_count", 32'(t_s2v), 32'd1);
        chk("nom_busy_after", 32'(busy), 32'd0);
        step();

        // Early samples before sigma2
        clear_tally();
        start(2);
        in_vld = 1;
        for (int i = 0; i < 5; i++) begin
            in_re = 12'($urandom); in_im = 12'($urandom);
            step();
        end
        in_vld = 0;
        load_sigma(12'($urandom));
        feed(96, 0, 192, 100);
        wait_done(50);
        chk("early_drop_count", 32'(t_drop), 32'd5);
        chk("early_pd_count", 32'(t_pdv), 32'd96);

        // Gapped input, 1.5 symbols supplied for a 1-symbol frame
        clear_tally();
        start(1);
        load_sigma(12'($urandom));
        feed(72, 2, 96, 40);
        wait_done(100);
        chk("gap_pd_count", 32'(t_pdv), 32'd48);
        chk("gap_drop_count", 32'(t_drop), 32'd24);

        // Drain timeout after the 50th LLR
        clear_tally();
        start(1);
        load_sigma(12'($urandom));
        feed(48, 0, 50, 30);
        wait_done(TIMEOUT + 100);
        chk("to_count", 32'(t_to), 32'd1);
        chk("to_distance", 32'(to_edge - last_llr_edge), 32'(TIMEOUT));
        chk("to_done_next", 32'(done_edge - to_edge), 32'd1);

        // Zero-symbol start, then start ignored mid-RUN
        clear_tally();
        start(0);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_busy", 32'(busy), 32'd0);
        step();
        chk("zero_busy_after", 32'(busy), 32'd0);
        clear_tally();
        start(1);
        load_sigma(12'($urandom));
        feed(20, 0, 0, 0);
        cfg_start = 1; cfg_nsym = 8'd5;
        step();
        cfg_start = 0;
        feed(28, 0, 96, 40);
        wait_done(50);
        chk("restart_pd_count", 32'(t_pdv), 32'd48);

        // Reset mid-RUN, then a clean frame
        clear_tally();
        start(2);
        load_sigma(12'($urandom));
        feed(30, 0, 10, 10);
        rst = 1; in_vld = 1; in_re = 12'($urandom); in_im = 12'($urandom);
        step();
        chk("rst_mid_pd_vld", 32'(pd_vld), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        rst = 0; in_vld = 0;
        step();
        clear_tally();
        start(1);
        load_sigma(12'($urandom));
        feed(48, 1, 96, 40);
        wait_done(100);
        chk("post_rst_pd_count", 32'(t_pdv), 32'd48);
        chk("post_rst_drop", 32'(t_drop), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
